// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and word geometry for the instruction loader
package loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts bytes little-endian into a 32-bit word and pulses word_valid one cycle after the 4th byte
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        last,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] cnt;
  assign last = cnt == 2'(BYTES_PER_WORD - 1);
  // byte counter, shift register and the registered word strobe
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && last;
      if (clear) cnt <= '0;
      else if (accept) begin
        cnt <= cnt + 2'd1;
        word <= {byte_in, word[31:8]};
      end
    end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: length-prefixed byte stream to instruction-memory writer; INSTR_LOADER_CHECKSUM_EN adds a trailing XOR check byte
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error
);
  state_t state, state_next;
  logic [15:0] len;
  logic [ADDR_W-1:0] idx;
  logic [31:0] len_in;
  logic fire, take, pack_last, final_word, chk_ok, busy_now, busy_next;
  assign byte_ready = state inside {LEN_LO, LEN_HI, DATA, CHK};
  assign fire = byte_valid && byte_ready;
  assign take = start && (state inside {IDLE, DONE, ERROR});
  assign len_in = {16'd0, byte_data, len[7:0]};
  assign final_word = 32'(idx) + 32'd1 == 32'(len);
  assign wr_addr = 32'({idx, 2'b00});
  assign busy_now = state inside {LEN_LO, LEN_HI, DATA, CHK};
  assign busy_next = state_next inside {LEN_LO, LEN_HI, DATA, CHK};
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
  logic [7:0] chk;
  assign chk_ok = byte_data == chk;
  // running XOR of length and payload bytes; the check byte itself is excluded
  always_ff @(posedge clk)
    if (reset || take) chk <= '0;
    else if (fire && state != CHK) chk <= chk ^ byte_data;
`else
  localparam state_t END_ST = DONE;
  assign chk_ok = 1'b1;
`endif
  byte_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clear(take),
    .accept(fire && state == DATA),
    .byte_in(byte_data),
    .last(pack_last),
    .word(wr_data),
    .word_valid(wr_en)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  // next-state: the final byte of the final word leaves DATA while its write is still pending
  always_comb begin
    state_next = state;
    if (take) state_next = LEN_LO;
    else if (fire)
      state_next = state == LEN_LO ? LEN_HI :
                   state == LEN_HI ? (len_in == 32'd0 ? END_ST :
                                      len_in > 32'(MAX_WORDS) ? ERROR : DATA) :
                   state == DATA   ? (pack_last && final_word ? END_ST : DATA) :
                   chk_ok ? DONE : ERROR;
  end
  // length capture and word index; the index holds on the final word so it never passes MAX_WORDS-1
  always_ff @(posedge clk)
    if (reset || take) begin
      len <= '0;
      idx <= '0;
    end else begin
      if (fire && state == LEN_LO) len[7:0] <= byte_data;
      if (fire && state == LEN_HI) len <= len_in[15:0];
      if (wr_en && !final_word) idx <= idx + ADDR_W'(1);
    end
  // status flags settle one cycle after entering DONE/ERROR so done lines up after the last write
  always_ff @(posedge clk)
    if (reset) begin
      core_hold <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      core_hold <= busy_now || busy_next;
      done <= state == DONE && state_next == DONE;
      error <= state == ERROR && state_next == ERROR;
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven, hand-written and randomized checks of instr_loader against a stream-level model
module tb_instr_loader;
  localparam int ADDR_W = 4;
  localparam int MAX_WORDS = 4;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_ready, wr_en, core_hold, done, error;
  logic [31:0] wr_addr, wr_data;
  int n_checks = 0, n_fail = 0;
  logic [63:0] wq[$];
  logic [7:0] stream[$];

  typedef struct {
    int len;
    bit gap;
    bit exp_done;
    bit exp_err;
    int exp_writes;
  } vec_t;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_hold(core_hold),
    .done(done), .error(error)
  );

  always @(posedge clk) begin
    #2;
    if (wr_en) wq.push_back({wr_addr, wr_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_data = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake: got byte_ready=0 for 16 cycles required 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // stream = length header, 4*len random payload bytes (when legal), optional XOR byte
  task automatic build(input int len, input bit flip);
    logic [7:0] x = '0;
    stream.delete();
    stream.push_back(8'(len));
    stream.push_back(8'(len >> 8));
    if (len <= MAX_WORDS) begin
      for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom));
      foreach (stream[i]) x ^= stream[i];
      if (CHK_EN) stream.push_back(flip ? ~x : x);
    end
  endtask

  task automatic load(input bit gap);
    pulse_start;
    check("start_clears_done", 32'(done), 0);
    check("start_clears_error", 32'(error), 0);
    check("start_sets_hold", 32'(core_hold), 1);
    wq.delete();
    foreach (stream[i]) begin
      if (gap && i > 0) begin
        start = (i == 4);
        @(negedge clk);
        start = 1'b0;
      end
      send(stream[i]);
    end
    tick(3);
  endtask

  // model: words are consecutive little-endian groups of payload bytes at addresses 0,4,8...
  task automatic verify(input int len, input bit exp_done, input bit exp_err, input int nw);
    check("writes", wq.size(), nw);
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      check("wr_addr", wq[i][63:32], 32'(4 * i));
      check("wr_data", wq[i][31:0],
            {stream[5 + 4 * i], stream[4 + 4 * i], stream[3 + 4 * i], stream[2 + 4 * i]});
    end
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    check("hold_released", 32'(core_hold), 0);
    check("ready_low", 32'(byte_ready), 0);
    check("len_echo", 32'({stream[1], stream[0]}), 32'(len));
  endtask

  initial begin
    vec_t tbl[7];
    int len;
    bit flip, gap, e;
    tbl = '{'{0, 0, 1, 0, 0}, '{1, 0, 1, 0, 1}, '{4, 1, 1, 0, 4}, '{5, 0, 0, 1, 0},
            '{256, 1, 0, 1, 0}, '{2, 1, 1, 0, 2}, '{3, 0, 1, 0, 3}};
    tick(2);
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_hold", 32'(core_hold), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    reset = 1'b0;
    tick(1);

    // nominal two-word program with exact write and done timing
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    pulse_start;
    wq.delete();
    foreach (stream[i]) send(stream[i]);
    check("nom_wr_en", 32'(wr_en), 1);
    check("nom_addr1", wr_addr, 32'h4);
    check("nom_data1", wr_data, 32'h00A00593);
    check("nom_hold_during", 32'(core_hold), 1);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h72);
    check("nom_done_early", 32'(done), 0);
`endif
    tick(1);
    check("nom_done", 32'(done), 1);
    check("nom_hold", 32'(core_hold), 0);
    check("nom_wr_en_off", 32'(wr_en), 0);
    check("nom_writes", wq.size(), 2);
    if (wq.size() > 0) check("nom_word0", wq[0][31:0], 32'h00500513);
    if (wq.size() > 0) check("nom_addr0", wq[0][63:32], 32'h0);

    // zero length
    pulse_start;
    wq.delete();
    send(8'h00);
    send(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("len0_done_early", 32'(done), 0);
    check("len0_hold_early", 32'(core_hold), 1);
    tick(1);
    check("len0_done", 32'(done), 1);
    check("len0_hold", 32'(core_hold), 0);
    check("len0_writes", wq.size(), 0);

    // oversize length
    pulse_start;
    wq.delete();
    send(8'h05);
    send(8'h00);
    check("over_ready", 32'(byte_ready), 0);
    check("over_err_early", 32'(error), 0);
    tick(1);
    check("over_error", 32'(error), 1);
    check("over_hold", 32'(core_hold), 0);
    tick(2);
    check("over_writes", wq.size(), 0);

    // reset after two bytes of word 1
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05};
    pulse_start;
    wq.delete();
    foreach (stream[i]) send(stream[i]);
    check("mid_hold", 32'(core_hold), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_ready", 32'(byte_ready), 0);
    check("mid_hold_drop", 32'(core_hold), 0);
    check("mid_wr_en", 32'(wr_en), 0);
    check("mid_addr", wr_addr, 0);
    check("mid_data", wr_data, 0);
    check("mid_done", 32'(done), 0);
    check("mid_error", 32'(error), 0);
    tick(2);
    check("mid_writes", wq.size(), 1);
    build(2, 1'b0);
    load(1'b0);
    verify(2, 1'b1, 1'b0, 2);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // corrupted check byte: words land, error flags the mismatch
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h8D};
    load(1'b0);
    verify(2, 1'b0, 1'b1, 2);
`endif

    // table of lengths with hand-stated outcomes
    foreach (tbl[k]) begin
      build(tbl[k].len, 1'b0);
      load(tbl[k].gap);
      verify(tbl[k].len, tbl[k].exp_done, tbl[k].exp_err, tbl[k].exp_writes);
    end

    // randomized loads against the model
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(0, MAX_WORDS + 2);
      flip = 1'($urandom_range(0, 1));
      gap = 1'($urandom_range(0, 1));
      e = len > MAX_WORDS || (CHK_EN && flip);
      build(len, flip);
      load(gap);
      verify(len, !e, e, len > MAX_WORDS ? 0 : len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
